// File: rtl/zxuno_uart_pkg.sv
// Shared constants for the ZX-Uno UART: register addresses, status bit indices and FSM states.
// The optional RX FIFO is enabled with ZXUNO_UART_RXFIFO_EN.
package zxuno_uart_pkg;

  localparam logic [7:0] UARTDATA = 8'hC6;
  localparam logic [7:0] UARTSTAT = 8'hC7;

  localparam int RXV = 7;
  localparam int TXB = 6;
  localparam int OVR = 5;
  localparam int FER = 4;
  localparam int FUL = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/zxuno_uart_rx.sv
// UART receiver: input synchronizer, mid-bit sampling FSM and receive holding storage.
// With ZXUNO_UART_RXFIFO_EN defined the holding register becomes a 16-entry FIFO.
module zxuno_uart_rx
  import zxuno_uart_pkg::*;
#(
  parameter int DIV = 243
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       pop,
  output logic [7:0] data,
  output logic       valid,
  output logic       full,
  output logic       ferr_set,
  output logic       ovr_set
);

  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  logic        rx_meta, rx_sync, rx_prev;
  uart_state_t state;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic        byte_vld, byte_ferr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      byte_ferr <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      byte_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= START;
            cnt   <= HALF_M1;
          end
        end
        START: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (rx_sync) begin
            // Line back high at mid start bit: treat as a glitch.
            state <= IDLE;
          end else begin
            state <= DATA;
            cnt   <= DIV_M1;
            bitn  <= '0;
          end
        end
        DATA: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            shreg <= {rx_sync, shreg[7:1]};
            cnt   <= DIV_M1;
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else begin
            state     <= IDLE;
            byte_vld  <= 1'b1;
            byte_ferr <= ~rx_sync;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ferr_set = byte_vld & byte_ferr;

`ifdef ZXUNO_UART_RXFIFO_EN
  logic [7:0] mem [16];
  logic [3:0] wptr, rptr;
  logic [4:0] count;
  logic       push, pop_ok;

  assign full   = (count == 5'd16);
  assign valid  = (count != 5'd0);
  assign push   = byte_vld & ~full;
  assign pop_ok = pop & valid;
  assign data   = valid ? mem[rptr] : 8'h00;
  assign ovr_set = byte_vld & full;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 4'd1;
      if (pop_ok) rptr <= rptr + 4'd1;
      count <= count + {4'd0, push} - {4'd0, pop_ok};
    end
  end
`else
  logic [7:0] hold;
  logic       hold_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold     <= 8'h00;
      hold_vld <= 1'b0;
    end else if (byte_vld) begin
      hold     <= shreg;
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end

  assign data    = hold;
  assign valid   = hold_vld;
  assign full    = 1'b0;
  assign ovr_set = byte_vld & hold_vld;
`endif

endmodule

// File: rtl/zxuno_uart.sv
// ZX-Uno 8N1 UART on register-bank entries UARTDATA/UARTSTAT: transmitter, register decode, sticky status.
// Optional 16-entry RX FIFO selected by ZXUNO_UART_RXFIFO_EN.
module zxuno_uart
  import zxuno_uart_pkg::*;
#(
  parameter int         CLK_HZ   = 28000000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] UARTDATA = 8'hC6,
  parameter logic [7:0] UARTSTAT = 8'hC7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam int          DIV    = calc_div(CLK_HZ, BAUD);
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  logic        regwr_d, regrd_d;
  logic [7:0]  rd_addr;
  logic        wr_rise, rd_fall, pop, stat_clr;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_full, ferr_set, ovr_set;
  logic        overrun, ferr, tx_busy;
  logic [7:0]  status;
  logic        sel;

  uart_state_t tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;

  // The read address is captured while regrd is high so the side-effect on the falling edge is unambiguous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwr_d <= 1'b0;
      regrd_d <= 1'b0;
      rd_addr <= 8'h00;
    end else begin
      regwr_d <= zxuno_regwr;
      regrd_d <= zxuno_regrd;
      if (zxuno_regrd) rd_addr <= zxuno_addr;
    end
  end

  assign wr_rise  = zxuno_regwr & ~regwr_d;
  assign rd_fall  = regrd_d & ~zxuno_regrd;
  assign pop      = rd_fall & (rd_addr == UARTDATA);
  assign stat_clr = rd_fall & (rd_addr == UARTSTAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_busy  <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (wr_rise && zxuno_addr == UARTDATA) begin
            tx_sh    <= din;
            tx_busy  <= 1'b1;
            uart_tx  <= 1'b0;
            tx_cnt   <= DIV_M1;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            uart_tx  <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= DIV_M1;
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt <= DIV_M1;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= STOP;
            end else begin
              uart_tx <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
              tx_bit  <= tx_bit + 3'd1;
            end
          end
        end
        STOP: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_busy  <= 1'b0;
            tx_state <= IDLE;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  zxuno_uart_rx #(.DIV(DIV)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (uart_rx),
    .pop      (pop),
    .data     (rx_data),
    .valid    (rx_valid),
    .full     (rx_full),
    .ferr_set (ferr_set),
    .ovr_set  (ovr_set)
  );

  // Sticky error flags: a set in the same clock as the status read wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (ovr_set)       overrun <= 1'b1;
      else if (stat_clr) overrun <= 1'b0;
      if (ferr_set)      ferr <= 1'b1;
      else if (stat_clr) ferr <= 1'b0;
    end
  end

  always_comb begin
    status      = 8'h00;
    status[RXV] = rx_valid;
    status[TXB] = tx_busy;
    status[OVR] = overrun;
    status[FER] = ferr;
    status[FUL] = rx_full;
  end

  assign sel  = zxuno_regrd & ((zxuno_addr == UARTDATA) | (zxuno_addr == UARTSTAT));
  assign oe_n = ~sel;
  assign dout = !sel ? 8'h00 : (zxuno_addr == UARTDATA) ? rx_data : status;

endmodule

// File: tb/tb_zxuno_uart.sv
// Bench for zxuno_uart at 1 MHz / 100 kbaud (10 clocks per bit); covers both builds of ZXUNO_UART_RXFIFO_EN.
module tb_zxuno_uart;

  localparam logic [7:0] A_DATA = 8'hC6;
  localparam logic [7:0] A_STAT = 8'hC7;
`ifdef ZXUNO_UART_RXFIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd, zxuno_regwr;
  logic [7:0] din, dout;
  logic       oe_n, uart_tx, uart_rx;

  int checks = 0;
  int failures = 0;

  zxuno_uart #(.CLK_HZ(1000000), .BAUD(100000), .UARTDATA(A_DATA), .UARTSTAT(A_STAT)) dut (
    .clk(clk), .reset(reset), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .din(din), .dout(dout), .oe_n(oe_n),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  // Reference model: bytes waiting to be read plus sticky flags.
  logic [7:0] q[$];
  bit         m_ovr, m_ferr;
  logic [7:0] m_last;

  function automatic void model_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_last = 8'h00;
  endfunction

  function automatic void model_rx(input logic [7:0] b, input logic stop);
    if (FIFO) begin
      if (q.size() >= 16) m_ovr = 1'b1;
      else q.push_back(b);
    end else begin
      if (q.size() != 0) begin
        m_ovr = 1'b1;
        q[0] = b;
      end else begin
        q.push_back(b);
      end
      m_last = b;
    end
    if (!stop) m_ferr = 1'b1;
  endfunction

  function automatic logic [7:0] exp_stat();
    return {q.size() != 0, 1'b0, m_ovr, m_ferr, FIFO && q.size() == 16, 3'b000};
  endfunction

  function automatic logic [7:0] exp_data();
    if (FIFO) return (q.size() != 0) ? q[0] : 8'h00;
    return m_last;
  endfunction

  function automatic void model_read(input logic [7:0] a);
    if (a == A_DATA) begin
      if (q.size() != 0) void'(q.pop_front());
    end else begin
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
    logic [7:0] v;
    logic       oe;
    @(negedge clk);
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    @(negedge clk);
    v  = dout;
    oe = oe_n;
    @(negedge clk);
    zxuno_regrd = 1'b0;
    repeat (2) @(negedge clk);
    check({name, " oe_n"}, {31'd0, oe}, 32'd0);
    check(name, {24'd0, v}, {24'd0, exp});
    model_read(a);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    zxuno_addr  = a;
    din         = d;
    zxuno_regwr = 1'b1;
    repeat (2) @(negedge clk);
    zxuno_regwr = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rx = stop;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    model_rx(b, stop);
  endtask

  task automatic glitch();
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (120) @(negedge clk);
  endtask

  // Waits for a start bit and samples each bit at its middle; returns at mid stop bit.
  task automatic capture(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    b  = 8'h00;
    while (uart_tx !== 1'b0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) return;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(posedge clk);
      #1;
      b[i] = uart_tx;
    end
    repeat (10) @(posedge clk);
    #1;
    ok = (uart_tx === 1'b1);
  endtask

  task automatic tx_chk(input logic [7:0] d, input string name);
    logic [7:0] b;
    bit         ok;
    fork
      capture(b, ok);
      wr(A_DATA, d);
    join
    check({name, " framed"}, {31'd0, ok}, 32'd1);
    check(name, {24'd0, b}, {24'd0, d});
    repeat (10) @(negedge clk);
  endtask

  typedef enum logic [1:0] {OP_RX, OP_RDS, OP_RDD, OP_GLITCH} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] val;
    logic       stop;
    logic [7:0] exp;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    vec_t       vecs[18];
    logic [7:0] b, wave;
    bit         ok;
    int         bad_tx, bad_st, hi_bad;

    vecs[0]  = '{OP_RX,     8'h3C, 1'b1, 8'h00};
    vecs[1]  = '{OP_RDS,    8'h00, 1'b1, 8'h80};
    vecs[2]  = '{OP_RDD,    8'h00, 1'b1, 8'h3C};
    vecs[3]  = '{OP_RDS,    8'h00, 1'b1, 8'h00};
    vecs[4]  = '{OP_RX,     8'h01, 1'b1, 8'h00};
    vecs[5]  = '{OP_RX,     8'h02, 1'b1, 8'h00};
    vecs[6]  = '{OP_RDS,    8'h00, 1'b1, FIFO ? 8'h80 : 8'hA0};
    vecs[7]  = '{OP_RDS,    8'h00, 1'b1, 8'h80};
    vecs[8]  = '{OP_RDD,    8'h00, 1'b1, FIFO ? 8'h01 : 8'h02};
    vecs[9]  = '{OP_RDD,    8'h00, 1'b1, 8'h02};
    vecs[10] = '{OP_RDS,    8'h00, 1'b1, 8'h00};
    vecs[11] = '{OP_RX,     8'h5A, 1'b0, 8'h00};
    vecs[12] = '{OP_RDS,    8'h00, 1'b1, 8'h90};
    vecs[13] = '{OP_RDS,    8'h00, 1'b1, 8'h80};
    vecs[14] = '{OP_RDD,    8'h00, 1'b1, 8'h5A};
    vecs[15] = '{OP_RDS,    8'h00, 1'b1, 8'h00};
    vecs[16] = '{OP_GLITCH, 8'h00, 1'b1, 8'h00};
    vecs[17] = '{OP_RDS,    8'h00, 1'b1, 8'h00};

    reset = 1'b1; zxuno_addr = 8'h00; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0;
    din = 8'h00; uart_rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset oe_n", {31'd0, oe_n}, 32'd1);
    check("reset dout idle", {24'd0, dout}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    rd_chk(A_STAT, 8'h00, "reset stat");
    rd_chk(A_DATA, 8'h00, "reset data");
    wr(A_STAT, 8'hFF);
    check("stat write ignored", {31'd0, uart_tx}, 32'd1);

    // Exact TX waveform for 0xA5 with status held on the bus throughout.
    wave = 8'hA5;
    bad_tx = 0; bad_st = 0;
    @(negedge clk);
    zxuno_addr = A_DATA; din = wave; zxuno_regwr = 1'b1;
    @(posedge clk); #1;
    zxuno_regwr = 1'b0; zxuno_addr = A_STAT; zxuno_regrd = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      logic exp_tx;
      #1;
      exp_tx = (i < 10) ? 1'b0 : (i < 90) ? wave[(i - 10) / 10] : 1'b1;
      if (uart_tx !== exp_tx) bad_tx++;
      if (dout !== ((i < 100) ? 8'h40 : 8'h00)) bad_st++;
      @(posedge clk); #1;
    end
    zxuno_regrd = 1'b0;
    model_read(A_STAT);
    check("tx A5 waveform bad samples", bad_tx, 0);
    check("tx A5 busy status bad samples", bad_st, 0);

    // Second write while busy is dropped.
    fork
      capture(b, ok);
      begin
        wr(A_DATA, 8'h11);
        repeat (20) @(negedge clk);
        wr(A_DATA, 8'h22);
      end
    join
    check("busy drop first byte", {24'd0, b}, 32'h11);
    hi_bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) hi_bad++;
    end
    check("busy drop no second frame", hi_bad, 0);
    rd_chk(A_STAT, 8'h00, "stat after drop");

    for (int i = 0; i < 18; i++) begin
      case (vecs[i].op)
        OP_RX:     send_rx(vecs[i].val, vecs[i].stop);
        OP_GLITCH: glitch();
        OP_RDS:    rd_chk(A_STAT, vecs[i].exp, $sformatf("vec%0d stat", i));
        default:   rd_chk(A_DATA, vecs[i].exp, $sformatf("vec%0d data", i));
      endcase
    end

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: send_rx(8'($urandom), $urandom_range(0, 7) != 0);
        1: rd_chk(A_DATA, exp_data(), $sformatf("rand%0d data", i));
        2: rd_chk(A_STAT, exp_stat(), $sformatf("rand%0d stat", i));
        default: tx_chk(8'($urandom), $sformatf("rand%0d tx", i));
      endcase
    end
    while (q.size() != 0) rd_chk(A_DATA, exp_data(), "drain data");
    rd_chk(A_STAT, exp_stat(), "drain stat");
    rd_chk(A_STAT, 8'h00, "drained stat");

`ifdef ZXUNO_UART_RXFIFO_EN
    for (int i = 0; i < 17; i++) send_rx(8'($urandom), 1'b1);
    rd_chk(A_STAT, 8'hA8, "fifo full stat");
    for (int i = 0; i < 16; i++) rd_chk(A_DATA, exp_data(), $sformatf("fifo pop%0d", i));
    rd_chk(A_STAT, 8'h00, "fifo empty stat");
`endif

    // Reset in the middle of a TX frame.
    wr(A_DATA, 8'h00);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    zxuno_addr = A_STAT; zxuno_regrd = 1'b1;
    #1;
    check("mid-frame reset uart_tx", {31'd0, uart_tx}, 32'd1);
    check("mid-frame reset stat", {24'd0, dout}, 32'd0);
    zxuno_regrd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    hi_bad = 0;
    repeat (120) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) hi_bad++;
    end
    check("no frame after reset", hi_bad, 0);
    rd_chk(A_STAT, 8'h00, "stat after reset");
    tx_chk(8'hC3, "tx after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
